fetch_pc_gen: RTL and testbench

Fetch-stage program-counter generator that sits directly downstream of the branch computation unit and upstream of instruction memory. It holds the architectural fetch PC, issues sequential instruction-memory requests over a valid/ready handshake, and honours stalls. On a resolved branch or jump it redirects to the target and squashes younger pipeline stages for a fixed number of cycles.

---
 rtl/fetch_pc_gen.sv | 84 ++++++++
 tb/tb_fetch_pc_gen.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: issues sequential instruction-memory requests over
// valid/ready, holds them across stalls, and redirects with a fixed-length flush.
module fetch_pc_gen #(
    parameter int                      ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC     = '0,
    parameter int                      PC_STEP      = 1,
    parameter int                      FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  system_stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    output logic                  fetch_valid_out,
    output logic [ADDR_WIDTH-1:0] fetch_pc_out,
    output logic                  flush_out,
    output logic [15:0]           redirect_cnt
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  req_pending;
    logic [CNT_W-1:0]      flush_cnt;
    logic                  accept;

    // A request already presented to memory stays up through a stall until taken.
    assign imem_req_valid = (state == RUN) && !redirect_valid && (!system_stall || req_pending);
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign flush_out      = (state == FLUSH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= BOOT;
            pc_q            <= RESET_PC;
            req_pending     <= 1'b0;
            flush_cnt       <= '0;
            fetch_valid_out <= 1'b0;
            fetch_pc_out    <= '0;
            redirect_cnt    <= '0;
        end else begin
            fetch_valid_out <= accept;
            if (accept)
                fetch_pc_out <= pc_q;

            if (redirect_valid && state != BOOT) begin
                pc_q            <= redirect_pc;
                req_pending     <= 1'b0;
                state           <= FLUSH;
                flush_cnt       <= CNT_W'(FLUSH_CYCLES - 1);
                fetch_valid_out <= 1'b0;
                if (redirect_cnt != 16'hFFFF)
                    redirect_cnt <= redirect_cnt + 16'd1;
            end else begin
                case (state)
                    BOOT: state <= RUN;
                    RUN: begin
                        if (accept) begin
                            pc_q        <= pc_q + ADDR_WIDTH'(PC_STEP);
                            req_pending <= 1'b0;
                        end else if (imem_req_valid) begin
                            req_pending <= 1'b1;
                        end
                    end
                    FLUSH: begin
                        if (flush_cnt == '0)
                            state <= RUN;
                        else
                            flush_cnt <= flush_cnt - 1'b1;
                    end
                    default: state <= BOOT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Drives two fetch_pc_gen instances (RESET_PC 0 and a near-wrap RESET_PC) with
// directed and random stimulus, comparing every output against a cycle model.
module tb_fetch_pc_gen;

    localparam int FC = 2;

    logic clk = 1'b0;
    logic reset, system_stall, redirect_valid, imem_req_ready;
    logic [31:0] redirect_pc;

    logic [1:0]       rv, fv, fo;
    logic [1:0][31:0] ra, fpc;
    logic [1:0][15:0] rc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_pc_gen #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .PC_STEP(1), .FLUSH_CYCLES(FC)) dut0 (
        .clk(clk), .reset(reset), .system_stall(system_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(rv[0]), .imem_req_addr(ra[0]), .imem_req_ready(imem_req_ready),
        .fetch_valid_out(fv[0]), .fetch_pc_out(fpc[0]), .flush_out(fo[0]),
        .redirect_cnt(rc[0]));

    fetch_pc_gen #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFE), .PC_STEP(1), .FLUSH_CYCLES(FC)) dut1 (
        .clk(clk), .reset(reset), .system_stall(system_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(rv[1]), .imem_req_addr(ra[1]), .imem_req_ready(imem_req_ready),
        .fetch_valid_out(fv[1]), .fetch_pc_out(fpc[1]), .flush_out(fo[1]),
        .redirect_cnt(rc[1]));

    // Reference model: one entry per instance.
    bit [31:0] m_rst_pc [2] = '{32'h0, 32'hFFFF_FFFE};
    bit        m_boot   [2];
    int        m_flush  [2];   // flush cycles still to go
    bit [31:0] m_pc     [2];
    bit        m_pend   [2];
    bit        m_fv     [2];
    bit [31:0] m_fpc    [2];
    int        m_rcnt   [2];
    int        cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit exp_valid(input int i);
        return !m_boot[i] && m_flush[i] == 0 && !redirect_valid && (!system_stall || m_pend[i]);
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit v, acc;
            v   = exp_valid(i);
            acc = v && imem_req_ready;
            if (reset) begin
                m_boot[i] = 1; m_pc[i] = m_rst_pc[i]; m_pend[i] = 0; m_flush[i] = 0;
                m_fv[i] = 0; m_fpc[i] = 0; m_rcnt[i] = 0;
            end else if (m_boot[i]) begin
                m_boot[i] = 0; m_fv[i] = 0;
            end else if (redirect_valid) begin
                m_pc[i] = redirect_pc; m_pend[i] = 0; m_flush[i] = FC; m_fv[i] = 0;
                if (m_rcnt[i] < 65535) m_rcnt[i]++;
            end else begin
                m_fv[i] = acc;
                if (acc) begin
                    m_fpc[i] = m_pc[i]; m_pc[i] = m_pc[i] + 32'd1; m_pend[i] = 0;
                end else if (v) begin
                    m_pend[i] = 1;
                end
                if (m_flush[i] > 0) m_flush[i]--;
            end
        end
    endtask

    // Inputs are already set; check outputs mid-cycle, then advance model at the edge.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("req_valid%0d", i), 32'(rv[i]), 32'(exp_valid(i)));
            check($sformatf("req_addr%0d", i), ra[i], m_pc[i]);
            check($sformatf("fetch_valid%0d", i), 32'(fv[i]), 32'(m_fv[i]));
            check($sformatf("fetch_pc%0d", i), fpc[i], m_fpc[i]);
            check($sformatf("flush%0d", i), 32'(fo[i]), 32'(m_flush[i] > 0));
            check($sformatf("redirect_cnt%0d", i), 32'(rc[i]), 32'(m_rcnt[i]));
        end
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic drive(input bit r, input bit st, input bit rd, input bit [31:0] rpc, input bit rdy);
        reset = r; system_stall = st; redirect_valid = rd; redirect_pc = rpc; imem_req_ready = rdy;
        step();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_boot[i] = 1; m_pc[i] = m_rst_pc[i]; m_pend[i] = 0; m_flush[i] = 0;
            m_fv[i] = 0; m_fpc[i] = 0; m_rcnt[i] = 0;
        end
        reset = 1; system_stall = 0; redirect_valid = 0; redirect_pc = 0; imem_req_ready = 1;
        @(posedge clk); #1;

        // Reset 3 cycles, then free-running fetch (also exercises wrap on dut1).
        repeat (3) drive(1, 0, 0, 0, 1);
        // Redirect during BOOT must be ignored.
        drive(0, 0, 1, 32'h999, 1);
        repeat (5) drive(0, 0, 0, 0, 1);
        // Back-pressure at a held address, stall rising in the 2nd not-ready cycle.
        drive(0, 0, 0, 0, 0);
        repeat (3) drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 1);
        repeat (2) drive(0, 1, 0, 0, 1);
        repeat (3) drive(0, 0, 0, 0, 1);
        // Single redirect.
        drive(0, 0, 1, 32'h40, 1);
        repeat (4) drive(0, 0, 0, 0, 1);
        // Redirect inside FLUSH restarts the window.
        drive(0, 0, 1, 32'h80, 1);
        drive(0, 0, 1, 32'h100, 1);
        repeat (4) drive(0, 0, 0, 0, 1);
        // Reset during FLUSH with a pending request beforehand.
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 1, 32'h200, 0);
        drive(1, 1, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 1);
        // Stall raised on the accepting cycle.
        drive(0, 0, 0, 0, 1);
        repeat (2) drive(0, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 1);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            bit r, st, rd, rdy;
            r   = ($urandom_range(0, 99) < 1);
            st  = ($urandom_range(0, 99) < 30);
            rd  = ($urandom_range(0, 99) < 6);
            rdy = ($urandom_range(0, 99) < 70);
            drive(r, st, rd, $urandom, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
